// File: rtl/gf180mcu_fd_sc_mcu9t5v0_decap_seq.sv
// Staged enable controller for switchable decap segments: ramps a thermometer-coded
// segment mask up/down one bit per STEP_CYC cycles. Optional HOLD port via GF180MCU_DECAP_SEQ_HOLD_EN.
module gf180mcu_fd_sc_mcu9t5v0_decap_seq #(
    parameter int NSEG     = 8,
    parameter int STEP_CYC = 16
) (
`ifdef USE_POWER_PINS
    inout  wire             VDD,
    inout  wire             VSS,
`endif
    input  logic            CLK,
    input  logic            RN,
    input  logic            EN,
`ifdef GF180MCU_DECAP_SEQ_HOLD_EN
    input  logic            HOLD,
`endif
    output logic [NSEG-1:0] SEG,
    output logic            DONE,
    output logic            BUSY,
    output logic [1:0]      dbg_state
);

    localparam int CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        ON      = 2'd2,
        RAMP_DN = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [NSEG-1:0] seg_n;
    logic [NSEG-1:0] seg_up;
    logic [NSEG-1:0] seg_dn;
    logic            done_n;
    logic            up_full;
    logic            dn_empty;
    logic            step;
    logic            hold;

`ifdef GF180MCU_DECAP_SEQ_HOLD_EN
    assign hold = HOLD;
`else
    assign hold = 1'b0;
`endif

    // Thermometer code makes "set next bit" a shift-in of 1 and "clear top bit" a shift right.
    assign seg_up   = (SEG << 1) | NSEG'(1);
    assign seg_dn   = SEG >> 1;
    assign up_full  = &seg_up;
    assign dn_empty = (seg_dn == '0);
    assign step     = (cnt == LAST);

    assign dbg_state = state;

    always_comb begin
        state_n = state;
        seg_n   = SEG;
        cnt_n   = cnt;
        done_n  = DONE;
        if (!hold) begin
            unique case (state)
                IDLE: begin
                    if (EN) begin
                        seg_n = seg_up;
                        cnt_n = '0;
                        if (up_full) begin
                            state_n = ON;
                            done_n  = 1'b1;
                        end else begin
                            state_n = RAMP_UP;
                        end
                    end
                end
                RAMP_UP: begin
                    if (!EN) begin
                        seg_n   = seg_dn;
                        cnt_n   = '0;
                        state_n = dn_empty ? IDLE : RAMP_DN;
                    end else if (step) begin
                        seg_n = seg_up;
                        cnt_n = '0;
                        if (up_full) begin
                            state_n = ON;
                            done_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ON: begin
                    if (!EN) begin
                        seg_n   = seg_dn;
                        cnt_n   = '0;
                        done_n  = 1'b0;
                        state_n = dn_empty ? IDLE : RAMP_DN;
                    end
                end
                RAMP_DN: begin
                    if (EN) begin
                        seg_n = seg_up;
                        cnt_n = '0;
                        if (up_full) begin
                            state_n = ON;
                            done_n  = 1'b1;
                        end else begin
                            state_n = RAMP_UP;
                        end
                    end else if (step) begin
                        seg_n = seg_dn;
                        cnt_n = '0;
                        if (dn_empty) begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    seg_n   = '0;
                    cnt_n   = '0;
                    done_n  = 1'b0;
                end
            endcase
        end
    end

    // BUSY is registered from the next state so it tracks the ramp states exactly.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            SEG   <= '0;
            cnt   <= '0;
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_n;
            SEG   <= seg_n;
            cnt   <= cnt_n;
            DONE  <= done_n;
            BUSY  <= (state_n == RAMP_UP) || (state_n == RAMP_DN);
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_decap_seq.sv
// Directed bench for the decap sequencer: NSEG=4/STEP_CYC=3 main instance plus an
// NSEG=1/STEP_CYC=1 instance; HOLD scenario runs when GF180MCU_DECAP_SEQ_HOLD_EN is defined.
module tb_gf180mcu_fd_sc_mcu9t5v0_decap_seq;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_DN   = 2'd3;

    logic       clk = 1'b0;
    logic       rn;
    logic       en;
    logic       en1;
    logic       hold;
    logic [3:0] seg;
    logic       done;
    logic       busy;
    logic [1:0] st;
    logic [0:0] seg1;
    logic       done1;
    logic       busy1;
    logic [1:0] st1;

    int checks   = 0;
    int failures = 0;

    // Each entry is {done, busy, seg[3:0]} expected after one clock edge.
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0_decap_seq #(.NSEG(4), .STEP_CYC(3)) u_dut4 (
        .CLK       (clk),
        .RN        (rn),
        .EN        (en),
`ifdef GF180MCU_DECAP_SEQ_HOLD_EN
        .HOLD      (hold),
`endif
        .SEG       (seg),
        .DONE      (done),
        .BUSY      (busy),
        .dbg_state (st)
    );

    gf180mcu_fd_sc_mcu9t5v0_decap_seq #(.NSEG(1), .STEP_CYC(1)) u_dut1 (
        .CLK       (clk),
        .RN        (rn),
        .EN        (en1),
`ifdef GF180MCU_DECAP_SEQ_HOLD_EN
        .HOLD      (1'b0),
`endif
        .SEG       (seg1),
        .DONE      (done1),
        .BUSY      (busy1),
        .dbg_state (st1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic drain(input string tag);
        logic [5:0] e;
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            check($sformatf("%s_edge%0d", tag, k), {26'd0, done, busy, seg}, {26'd0, e});
            k++;
        end
    endtask

    task automatic push_ramp_up();
        push(6'h11, 3);
        push(6'h13, 3);
        push(6'h17, 3);
        push(6'h2F, 1);
    endtask

    task automatic push_ramp_dn();
        push(6'h17, 3);
        push(6'h13, 3);
        push(6'h11, 3);
        push(6'h00, 1);
    endtask

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rn   = 1'b1;
        en   = 1'b0;
        en1  = 1'b0;
        hold = 1'b0;
        #1 rn = 1'b0;
        tick();
        tick();
        check("reset_seg", {28'd0, seg}, 32'h0);
        check("reset_done", {31'd0, done}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        check("reset_state", {30'd0, st}, {30'd0, S_IDLE});
        check("reset_seg1", {31'd0, seg1}, 32'h0);

        #2 rn = 1'b1;
        tick();
        tick();
        check("idle_en0", {26'd0, done, busy, seg}, 32'h0);

        // Full ramp up then hold in ON.
        en = 1'b1;
        push_ramp_up();
        drain("ramp_up");
        check("on_state", {30'd0, st}, {30'd0, S_ON});
        tick();
        tick();
        check("on_hold", {26'd0, done, busy, seg}, 32'h2F);

        // Full ramp down to IDLE.
        en = 1'b0;
        push_ramp_dn();
        drain("ramp_dn");
        check("dn_idle_state", {30'd0, st}, {30'd0, S_IDLE});

        // Reverse from RAMP_UP at SEG=0011.
        en = 1'b1;
        push(6'h11, 3);
        push(6'h13, 1);
        drain("rev_up");
        en = 1'b0;
        tick();
        check("rev_first", {26'd0, done, busy, seg}, 32'h11);
        check("rev_state", {30'd0, st}, {30'd0, S_DN});
        push(6'h11, 2);
        push(6'h00, 1);
        drain("rev_dn");
        check("rev_idle", {30'd0, st}, {30'd0, S_IDLE});

        // Reverse from RAMP_DN straight back to full.
        en = 1'b1;
        push_ramp_up();
        drain("ramp_up2");
        en = 1'b0;
        tick();
        check("dn_then_up_a", {26'd0, done, busy, seg}, 32'h17);
        en = 1'b1;
        tick();
        check("dn_then_up_b", {26'd0, done, busy, seg}, 32'h2F);
        check("dn_then_up_state", {30'd0, st}, {30'd0, S_ON});
        en = 1'b0;
        push_ramp_dn();
        drain("ramp_dn2");

        // One-cycle EN glitch.
        en = 1'b1;
        tick();
        check("glitch_up", {26'd0, done, busy, seg}, 32'h11);
        en = 1'b0;
        tick();
        check("glitch_dn", {26'd0, done, busy, seg}, 32'h00);
        check("glitch_state", {30'd0, st}, {30'd0, S_IDLE});

        // Asynchronous reset mid-ramp at SEG=0111.
        en = 1'b1;
        push(6'h11, 3);
        push(6'h13, 3);
        push(6'h17, 1);
        drain("pre_rst");
        #2 rn = 1'b0;
        #1;
        check("async_rst_seg", {28'd0, seg}, 32'h0);
        check("async_rst_done", {31'd0, done}, 32'h0);
        check("async_rst_busy", {31'd0, busy}, 32'h0);
        check("async_rst_state", {30'd0, st}, {30'd0, S_IDLE});
        en = 1'b0;
        #2 rn = 1'b1;
        tick();
        check("post_rst_idle", {26'd0, done, busy, seg}, 32'h00);
        en = 1'b1;
        tick();
        check("post_rst_first", {26'd0, done, busy, seg}, 32'h11);
        en = 1'b0;
        tick();
        check("post_rst_back", {26'd0, done, busy, seg}, 32'h00);

        // NSEG=1, STEP_CYC=1 instance.
        en1 = 1'b1;
        tick();
        check("n1_seg", {31'd0, seg1}, 32'h1);
        check("n1_done", {31'd0, done1}, 32'h1);
        check("n1_busy", {31'd0, busy1}, 32'h0);
        check("n1_state", {30'd0, st1}, {30'd0, S_ON});
        tick();
        check("n1_hold", {30'd0, done1, busy1}, 32'h2);
        en1 = 1'b0;
        tick();
        check("n1_off", {29'd0, seg1, done1, busy1}, 32'h0);
        check("n1_off_state", {30'd0, st1}, {30'd0, S_IDLE});

`ifdef GF180MCU_DECAP_SEQ_HOLD_EN
        // HOLD for 5 edges at SEG=0011 delays 0111 by 5 cycles; EN is ignored while held.
        en = 1'b1;
        push(6'h11, 3);
        push(6'h13, 1);
        drain("hold_pre");
        hold = 1'b1;
        en   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_frozen%0d", i), {26'd0, done, busy, seg}, 32'h13);
        end
        check("hold_state", {30'd0, st}, {30'd0, S_UP});
        hold = 1'b0;
        en   = 1'b1;
        push(6'h13, 2);
        push(6'h17, 1);
        drain("hold_post");
        #2 rn = 1'b0;
        #2 rn = 1'b1;
        en = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0_decap_seq.md
# gf180mcu_fd_sc_mcu9t5v0_decap_seq

Staged enable controller for a bank of switchable decap segments built from the library's fillcap rows. It sits directly downstream of the passive fillcap fabric. When a block requests its decap bank, the controller switches segments on one at a time, paced by a step counter, to limit inrush current on VDD. On release it switches them off in reverse order.

## Interface
Parameters:
- NSEG, 8, number of switchable decap segments; legal range 1..32.
- STEP_CYC, 16, CLK cycles between successive segment changes; minimum 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RN  input  1  reset, asynchronous, active-low.
- VDD, VSS  inout  1 each  power pins; present only under USE_POWER_PINS, with no functional effect.
- EN  input  1  bank request; 1 = bank on, 0 = bank off.
- HOLD  input  1  pause ramp; present only with GF180MCU_DECAP_SEQ_HOLD_EN.
- SEG  output  NSEG  thermometer-coded segment enables; bit 0 switches first.
- DONE  output  1  all segments on, bank stable.
- BUSY  output  1  ramp in progress.

## Operation
- States: IDLE, RAMP_UP, ON, RAMP_DN.
- Registers: state, SEG, a step counter of width max(1, $clog2(STEP_CYC)), DONE, BUSY.
  - All outputs are registered.
  - SEG is always thermometer code: ones contiguous from bit 0.
- IDLE, EN=1:
  - SEG[0] is set on that edge.
  - Counter clears to 0.
  - If NSEG==1, go to ON; otherwise go to RAMP_UP.
- RAMP_UP:
  - Counter increments each cycle.
  - When counter==STEP_CYC-1, set the next SEG bit and clear the counter.
  - On the edge that SEG becomes all ones: go to ON and set DONE=1.
- ON: hold. On the edge EN is seen 0:
  - clear the highest set SEG bit;
  - set DONE=0;
  - clear the counter;
  - go to RAMP_DN, or to IDLE if SEG becomes 0.
- RAMP_DN:
  - Same pacing as RAMP_UP; clear the highest set bit each step.
  - Go to IDLE on the edge SEG becomes 0.
- Direction reversal:
  - EN=0 seen in RAMP_UP: clear the highest set bit on that edge, clear the counter, go to RAMP_DN.
  - EN=1 seen in RAMP_DN: set the next bit on that edge, clear the counter, go to RAMP_UP.
  - State transitions follow the same SEG-empty and SEG-full rules.
- BUSY = 1 exactly while the state is RAMP_UP or RAMP_DN.
- STEP_CYC==1: SEG changes by one bit on every edge.

## Timing
- Reset (RN low, asynchronous): SEG=0, DONE=0, BUSY=0, counter=0, state IDLE.
  - Reset asserted mid-ramp drops all segments at once.
  - After RN deasserts, the first possible change is at the first CLK edge that sees EN=1.
- Edge numbering: the enable edge is edge 0.
  - Bit k sets at edge k*STEP_CYC.
  - DONE rises at edge (NSEG-1)*STEP_CYC.
- Ramp-down mirrors ramp-up: the last bit clears at (NSEG-1)*STEP_CYC after the disable edge.
- EN is sampled once per edge and needs no synchronizer; the caller provides a CLK-domain signal.
- A glitch on EN lasting one cycle causes exactly one SEG step up and one step down.

## Configuration
- Macro: GF180MCU_DECAP_SEQ_HOLD_EN.
- Defined:
  - The HOLD input exists.
  - While HOLD=1, state, counter, SEG, DONE and BUSY all hold, and EN is ignored.
  - On HOLD deassertion, operation resumes with the preserved counter value.
- Undefined: no HOLD port; behaviour is identical to HOLD tied 0.

## Test plan
All scenarios use NSEG=4, STEP_CYC=3.
- Reset, then EN=1 at edge 0 -> SEG=0001@0, 0011@3, 0111@6, 1111@9 with DONE=1@9; BUSY=1 from edge 0 to edge 8.
- From ON, EN=0 at edge 0 -> DONE=0@0, SEG=0111@0, 0011@3, 0001@6, 0000@9, state IDLE@9.
- From SEG=0011 in RAMP_UP, EN=0 -> SEG=0001 on that edge, then 0000 three edges later, no overshoot.
- RN pulled low with SEG=0111 mid-ramp -> SEG=0000, DONE=0, BUSY=0 immediately, without waiting for CLK.
- STEP_CYC=1, NSEG=1 variant, EN=1 -> SEG=1 and DONE=1 on the same edge; BUSY never asserts.
- With the HOLD_EN build, HOLD=1 for 5 cycles at SEG=0011 -> SEG frozen; 0111 appears 5 cycles later than nominal.
